// File: rtl/canvas_paint_ctrl.sv
// Canvas paint sequencer: debounces the direction buttons, moves a wrapping cursor, and
// issues paint or full-canvas clear writes over one valid/ready port.
module canvas_paint_ctrl #(
  parameter int COORD_W         = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [3:0]             buttons,
  input  logic [2:0]             rgb_sel,
  input  logic                   brush,
  input  logic                   clear_req,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [2*COORD_W-1:0]   wr_addr,
  output logic [2:0]             wr_data,
  output logic [COORD_W-1:0]     cur_x,
  output logic [COORD_W-1:0]     cur_y,
  output logic                   busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

  logic [3:0] move_ev;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic             s1_q, s2_q;
      logic             deb_q, deb_d;
      logic             deb_prev_q;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // The count must saturate at DEBOUNCE_CYCLES while the level still differs
      // before the debounced state flips; any agreeing cycle restarts it.
      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            deb_d = s2_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q       <= 1'b0;
          s2_q       <= 1'b0;
          deb_q      <= 1'b0;
          deb_prev_q <= 1'b0;
          cnt_q      <= '0;
        end else begin
          s1_q       <= buttons[gi];
          s2_q       <= s1_q;
          deb_q      <= deb_d;
          deb_prev_q <= deb_q;
          cnt_q      <= cnt_d;
        end
      end

      assign move_ev[gi] = deb_q & ~deb_prev_q;
    end
  endgenerate

  state_t               state_q;
  logic                 wr_valid_q;
  logic [2*COORD_W-1:0] wr_addr_q;
  logic [2:0]           wr_data_q;
  logic [COORD_W-1:0]   cur_x_q, cur_y_q;
  logic [COORD_W-1:0]   cur_x_d, cur_y_d;
  logic                 busy_q;
  logic                 moved;

  logic ev_up, ev_down, ev_right, ev_left;
  assign ev_up    = move_ev[3];
  assign ev_down  = move_ev[2];
  assign ev_right = move_ev[1];
  assign ev_left  = move_ev[0];

  // Opposing events on one axis cancel; the other axis is unaffected.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    moved   = 1'b0;
    if (ev_up ^ ev_down) begin
      moved   = 1'b1;
      cur_y_d = ev_up ? cur_y_q - COORD_W'(1) : cur_y_q + COORD_W'(1);
    end
    if (ev_right ^ ev_left) begin
      moved   = 1'b1;
      cur_x_d = ev_right ? cur_x_q + COORD_W'(1) : cur_x_q - COORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ena && clear_req) begin
            state_q    <= CLEAR;
            wr_addr_q  <= '0;
            wr_data_q  <= 3'b000;
            wr_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (ena && moved) begin
            state_q    <= PAINT;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            wr_addr_q  <= {cur_y_d, cur_x_d};
            wr_data_q  <= brush ? rgb_sel : 3'b000;
            wr_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        PAINT: begin
          if (wr_ready) begin
            state_q    <= IDLE;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        CLEAR: begin
          if (wr_ready) begin
            if (&wr_addr_q) begin
              state_q    <= IDLE;
              wr_valid_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              wr_addr_q <= wr_addr_q + (2*COORD_W)'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          wr_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_canvas_paint_ctrl.sv
// Directed bench for canvas_paint_ctrl: button moves, debounce, wrap, backpressure,
// clear sweep and asynchronous reset during a clear.
module tb_canvas_paint_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] buttons;
  logic [2:0] rgb_sel;
  logic       brush;
  logic       clear_req;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [2:0] wr_data;
  logic [3:0] cur_x;
  logic [3:0] cur_y;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int xfer_addr[$];
  int xfer_data[$];

  localparam logic [3:0] B_UP = 4'b1000, B_DOWN = 4'b0100, B_RIGHT = 4'b0010, B_LEFT = 4'b0001;

  canvas_paint_ctrl #(.COORD_W(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .buttons(buttons), .rgb_sel(rgb_sel),
    .brush(brush), .clear_req(clear_req), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge, so values seen here decide the next edge.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      xfer_addr.push_back(int'(wr_addr));
      xfer_data.push_back(int'(wr_data));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int settle);
    buttons = b;
    wait_cyc(hold);
    buttons = 4'b0000;
    wait_cyc(settle);
  endtask

  initial begin
    int cycles;
    int seq_bad;
    int data_bad;
    rst_n = 1'b0; ena = 1'b1; buttons = 4'b0; rgb_sel = 3'b110; brush = 1'b1;
    clear_req = 1'b0; wr_ready = 1'b1;
    wait_cyc(2);
    chk("rst_cur_x", cur_x, 0);
    chk("rst_cur_y", cur_y, 0);
    chk("rst_valid", wr_valid, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Right press: first sampled at edge 0, cursor moves at edge 7.
    xfer_addr.delete(); xfer_data.delete();
    buttons = B_RIGHT;
    wait_cyc(7);
    chk("right_e6_x", cur_x, 0);
    chk("right_e6_valid", wr_valid, 0);
    wait_cyc(1);
    chk("right_e7_x", cur_x, 1);
    chk("right_e7_valid", wr_valid, 1);
    chk("right_e7_addr", wr_addr, 8'h01);
    chk("right_e7_data", wr_data, 3'b110);
    chk("right_e7_busy", busy, 1);
    wait_cyc(1);
    chk("right_e8_valid", wr_valid, 0);
    chk("right_e8_busy", busy, 0);
    wait_cyc(1);
    buttons = 4'b0;
    wait_cyc(15);
    chk("right_nxfer", xfer_addr.size(), 1);
    chk("right_xaddr", xfer_addr[0], 8'h01);
    chk("right_xdata", xfer_data[0], 3'b110);

    // Three-cycle glitch must be filtered out.
    xfer_addr.delete(); xfer_data.delete();
    press(B_RIGHT, 3, 15);
    chk("glitch_x", cur_x, 1);
    chk("glitch_nxfer", xfer_addr.size(), 0);

    // Valid press followed by a release bounce moves exactly once.
    buttons = B_RIGHT;
    wait_cyc(10);
    buttons = 4'b0;
    wait_cyc(2);
    buttons = B_RIGHT;
    wait_cyc(2);
    buttons = 4'b0;
    wait_cyc(15);
    chk("bounce_x", cur_x, 2);
    chk("bounce_nxfer", xfer_addr.size(), 1);

    // Wrap-around in eraser mode, starting from reset.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst2_cur_x", cur_x, 0);
    wait_cyc(1);
    rst_n = 1'b1;
    brush = 1'b0;
    wait_cyc(2);
    xfer_addr.delete(); xfer_data.delete();
    press(B_LEFT, 10, 15);
    chk("wrap_left_x", cur_x, 15);
    chk("wrap_left_nxfer", xfer_addr.size(), 1);
    chk("wrap_left_addr", xfer_addr[0], 8'h0F);
    chk("wrap_left_data", xfer_data[0], 0);
    xfer_addr.delete(); xfer_data.delete();
    press(B_UP, 10, 15);
    chk("wrap_up_y", cur_y, 15);
    chk("wrap_up_nxfer", xfer_addr.size(), 1);
    chk("wrap_up_addr", xfer_addr[0], 8'hFF);
    chk("wrap_up_data", xfer_data[0], 0);

    // Backpressure: down issues a write, a right event lands during the stall.
    xfer_addr.delete(); xfer_data.delete();
    brush = 1'b1; rgb_sel = 3'b101; wr_ready = 1'b0;
    buttons = B_DOWN;
    wait_cyc(3);
    buttons = B_DOWN | B_RIGHT;
    wait_cyc(5);
    chk("bp_valid", wr_valid, 1);
    chk("bp_addr", wr_addr, 8'h0F);
    chk("bp_data", wr_data, 3'b101);
    rgb_sel = 3'b011;
    for (int i = 0; i < 5; i++) begin
      wait_cyc(1);
      chk("bp_stall_valid", wr_valid, 1);
      chk("bp_stall_addr", wr_addr, 8'h0F);
      chk("bp_stall_data", wr_data, 3'b101);
    end
    wr_ready = 1'b1;
    wait_cyc(1);
    chk("bp_done_valid", wr_valid, 0);
    chk("bp_done_busy", busy, 0);
    buttons = 4'b0;
    wait_cyc(15);
    chk("bp_nxfer", xfer_addr.size(), 1);
    chk("bp_cur_x", cur_x, 15);
    chk("bp_cur_y", cur_y, 0);

    // Clear with a coincident right event and toggling ready.
    buttons = B_RIGHT;
    wait_cyc(7);
    clear_req = 1'b1;
    wait_cyc(1);
    clear_req = 1'b0;
    buttons = 4'b0;
    wr_ready = 1'b0;
    xfer_addr.delete(); xfer_data.delete();
    chk("clr_busy", busy, 1);
    chk("clr_valid", wr_valid, 1);
    chk("clr_addr0", wr_addr, 0);
    chk("clr_cur_x", cur_x, 15);
    wr_ready = 1'b1;
    cycles = 0;
    while (busy && cycles < 2000) begin
      wr_ready = ~wr_ready;
      wait_cyc(1);
      cycles++;
    end
    chk("clr_busy_cycles", cycles, 512);
    chk("clr_nxfer", xfer_addr.size(), 256);
    seq_bad = 0;
    data_bad = 0;
    for (int i = 0; i < xfer_addr.size(); i++) begin
      if (xfer_addr[i] != i) seq_bad++;
      if (xfer_data[i] != 0) data_bad++;
    end
    chk("clr_addr_seq", seq_bad, 0);
    chk("clr_data_zero", data_bad, 0);
    chk("clr_valid_end", wr_valid, 0);
    wr_ready = 1'b1;
    wait_cyc(15);
    chk("clr_cur_x_end", cur_x, 15);
    chk("clr_cur_y_end", cur_y, 0);

    // ena low blocks a clear request.
    ena = 1'b0;
    clear_req = 1'b1;
    wait_cyc(1);
    clear_req = 1'b0;
    chk("ena_busy", busy, 0);
    chk("ena_valid", wr_valid, 0);
    ena = 1'b1;
    wait_cyc(2);

    // Asynchronous reset in the middle of a clear sweep.
    clear_req = 1'b1;
    wait_cyc(1);
    clear_req = 1'b0;
    cycles = 0;
    while (wr_addr !== 8'h40 && cycles < 300) begin
      wait_cyc(1);
      cycles++;
    end
    chk("mid_addr40", wr_addr, 8'h40);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", wr_valid, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x", cur_x, 0);
    chk("mid_rst_y", cur_y, 0);
    chk("mid_rst_data", wr_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_idle_busy", busy, 0);
    xfer_addr.delete(); xfer_data.delete();
    clear_req = 1'b1;
    wait_cyc(1);
    clear_req = 1'b0;
    chk("reclr_addr0", wr_addr, 0);
    chk("reclr_valid", wr_valid, 1);
    cycles = 0;
    while (busy && cycles < 400) begin
      wait_cyc(1);
      cycles++;
    end
    chk("reclr_cycles", cycles, 256);
    chk("reclr_nxfer", xfer_addr.size(), 256);
    chk("reclr_first", xfer_addr[0], 0);
    chk("reclr_last", xfer_addr[255], 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
